fire4_scheduler: RTL and testbench
==================================

# fire4_scheduler

Sequencing controller for the fire4 module. It runs the squeeze layer first, then the two expand engines (expand1x1 and expand3x3) in parallel, and arbitrates their shared output-RAM write port. Each engine produces one 128-channel output vector per output pixel, flagged by a one-cycle sample pulse. The scheduler queues these vectors, grants one write per cycle and generates the write address. It drives the `ram_feedback` signal the engines use to qualify their finish outputs.

## Interface
Parameters:
- `WOUT`, 32, output feature-map width/height; `WOUT**2` pixels per engine.
- `AW`, `$clog2(WOUT**2)+1`, write address width; MSB = source select.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a fire4 pass. Accepted only in IDLE.
- `sq_finish`  in  1  squeeze layer done (level or pulse).
- `e1_sample`, `e3_sample`  in  1 each  expand1/expand3 output-vector-valid pulses.
- `e1_finish`, `e3_finish`  in  1 each  expand1/expand3 layer-finished indications.
- `sq_en`  out  1  squeeze enable.
- `e1_en`, `e3_en`  out  1 each  expand enables.
- `wr_en`  out  1  output RAM write strobe.
- `wr_sel`  out  1  write source: 0 = expand1, 1 = expand3.
- `wr_addr`  out  AW  write address = {`wr_sel`, pixel index of the selected source}.
- `ram_feedback`  out  1  high while any write is pending.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of pass.
- `err`  out  1  sticky error flag; cleared on an accepted `start`.

## Operation
- FSM states: IDLE, SQUEEZE, EXPAND, DONE.
  - IDLE → SQUEEZE on `start`.
  - SQUEEZE → EXPAND on `sq_finish`.
  - EXPAND → DONE when both finish latches are set.
  - DONE → IDLE unconditionally after 1 cycle.
- `sq_en` = 1 only in SQUEEZE. `e1_en` = `e3_en` = 1 only in EXPAND. All enables are registered.
- Finish latches `f1` and `f3` are set by `e1_finish` / `e3_finish` in EXPAND. They clear on entry to EXPAND.
- Sample pulses are counted only in EXPAND; outside EXPAND they are ignored. (The engines emit samples regardless of their enable.)
- Each source has a pending counter (0..2) and a pixel counter (0..`WOUT**2`-1).
  - A sample increments its pending counter.
  - A grant decrements it and increments that source's pixel counter.
  - Sample and grant to the same source in the same cycle: pending count is unchanged.
  - A sample arriving while pending = 2 is dropped and sets `err`.
- Arbitration is combinational from registered pending counts.
  - If only one source is pending, that source is granted.
  - If both are pending, grant is round-robin: the source not granted last wins. After reset, the last-grant register points to expand1, so expand3 wins the first tie.
- `wr_en` = grant valid. `wr_sel` = granted source. `wr_addr` = {`wr_sel`, pixel counter of that source}.
- `ram_feedback` = (`pend1` ≠ 0) | (`pend3` ≠ 0).
- On entering DONE: if either pixel counter total ≠ `WOUT**2`, set `err`. A pixel counter that wraps at `WOUT**2` counts as a total of `WOUT**2`; track this with a 1-bit wrap flag per source.
- An accepted `start` clears pending counters, pixel counters, wrap flags and `err`.
- `start` outside IDLE is ignored.

## Timing
- Reset (asynchronous): state = IDLE; all outputs 0; all counters, latches and `err` cleared; last-grant = expand1.
- `start` high in cycle t → `busy` = 1 and `sq_en` = 1 from t+1.
- `sq_finish` high in cycle t (state SQUEEZE) → `sq_en` = 0 and `e1_en` = `e3_en` = 1 from t+1.
- Sample in cycle t → pending = 1 in t+1 → `wr_en` in t+1 if uncontended.
  - On a tie, the loser writes in t+2.
  - Throughput: 1 write/cycle.
- `ram_feedback` rises in t+1 and falls in the cycle after the last pending write is granted.
- Both finish latches set at edge t → DONE in t+1 (`done` = 1, enables = 0) → IDLE in t+2.
- Pending writes are never cut off: the engines hold `finish` low while `ram_feedback` = 1.
- Reset asserted mid-pass: immediate return to IDLE. No write is issued after reset.

## Test plan
- Nominal pass, `WOUT` = 4:
  - Stimulus: `start`; `sq_finish` 10 cycles later; 16 `e1_sample` pulses spaced 33 cycles apart and 16 `e3_sample` pulses spaced 289 cycles apart; then both finishes.
  - Required: 32 writes; expand1 addresses 0..15 and expand3 addresses 16..31 in order; one `done` pulse; `err` = 0.
- Collision:
  - Stimulus: `e1_sample` and `e3_sample` in the same cycle, twice.
  - Required: first tie expand3 at t+1 then expand1 at t+2; second tie expand1 first, then expand3.
- Overflow:
  - Stimulus: three samples on one source while the other source holds the port.
  - Required: third sample dropped; `err` = 1; `err` cleared by the next `start`.
- Stray samples:
  - Stimulus: samples in IDLE and SQUEEZE.
  - Required: no `wr_en`; pixel counters stay 0.
- Count mismatch:
  - Stimulus: 15 expand1 samples with `WOUT` = 4, then both finishes.
  - Required: `err` = 1 with `done`.
- Async reset in EXPAND with pending = 2:
  - Required: all outputs 0 immediately; state IDLE; next `start` begins a clean pass.

Source files
------------

// File: rtl/fire4_scheduler_if.sv
// Handshake bundle between the fire4 scheduler, its three engines and the output RAM.
// The scheduler takes the slave view; engines/RAM side (or a bench) takes the master view.
interface fire4_scheduler_if #(
    parameter int AW = 11
);
    logic          start;
    logic          sq_finish;
    logic          e1_sample;
    logic          e3_sample;
    logic          e1_finish;
    logic          e3_finish;
    logic          sq_en;
    logic          e1_en;
    logic          e3_en;
    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic          ram_feedback;
    logic          busy;
    logic          done;
    logic          err;

    modport slave (
        input  start, sq_finish, e1_sample, e3_sample, e1_finish, e3_finish,
        output sq_en, e1_en, e3_en, wr_en, wr_sel, wr_addr, ram_feedback, busy, done, err
    );

    modport master (
        output start, sq_finish, e1_sample, e3_sample, e1_finish, e3_finish,
        input  sq_en, e1_en, e3_en, wr_en, wr_sel, wr_addr, ram_feedback, busy, done, err
    );
endinterface

// File: rtl/fire4_scheduler.sv
// Fire4 sequencer: squeeze, then expand1x1/expand3x3 in parallel, with a round-robin
// arbiter serialising both engines' output vectors onto the single RAM write port.
module fire4_scheduler #(
    parameter int WOUT = 32,
    parameter int AW   = $clog2(WOUT*WOUT) + 1
) (
    input  logic               clk,
    input  logic               rst,
    fire4_scheduler_if.slave   bus
);
    localparam int NPIX = WOUT * WOUT;
    localparam int PW   = AW - 1;

    typedef enum logic [1:0] {IDLE, SQUEEZE, EXPAND, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      pend1_q, pend1_d, pend3_q, pend3_d;
    logic [PW-1:0]   pix1_q, pix3_q;
    logic            wrap1_q, wrap3_q;
    logic            f1_q, f3_q;
    logic            last3_q;
    logic            err_q;

    logic            accept, enter_exp, enter_done, bad_count;
    logic            s1, s3, g1, g3, ovf1, ovf3;

    function automatic logic [1:0] pend_next(input logic [1:0] p, input logic s, input logic g);
        pend_next = p;
        if (s && !g && p != 2'd2) pend_next = p + 2'd1;
        else if (g && !s)         pend_next = p - 2'd1;
    endfunction

    // ---------------- FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // ---------------- FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)     state_d = SQUEEZE;
            SQUEEZE: if (bus.sq_finish) state_d = EXPAND;
            EXPAND:  if (f1_q && f3_q)  state_d = DONE;
            default:                    state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (decoded straight from the state flops)
    always_comb begin
        bus.busy  = (state_q != IDLE);
        bus.sq_en = (state_q == SQUEEZE);
        bus.e1_en = (state_q == EXPAND);
        bus.e3_en = (state_q == EXPAND);
        bus.done  = (state_q == DONE);
    end

    assign accept     = (state_q == IDLE) && bus.start;
    assign enter_exp  = (state_q == SQUEEZE) && bus.sq_finish;
    assign enter_done = (state_q == EXPAND) && (state_d == DONE);
    // A wrapped counter sitting at zero means exactly NPIX vectors were written.
    assign bad_count  = !(wrap1_q && pix1_q == '0) || !(wrap3_q && pix3_q == '0);

    // Engines pulse samples even when disabled, so only EXPAND counts them.
    assign s1 = (state_q == EXPAND) && bus.e1_sample;
    assign s3 = (state_q == EXPAND) && bus.e3_sample;

    // On a tie the source not granted last wins.
    assign g1 = (pend1_q != 2'd0) && ((pend3_q == 2'd0) || last3_q);
    assign g3 = (pend3_q != 2'd0) && ((pend1_q == 2'd0) || !last3_q);

    assign ovf1 = s1 && !g1 && (pend1_q == 2'd2);
    assign ovf3 = s3 && !g3 && (pend3_q == 2'd2);

    assign pend1_d = pend_next(pend1_q, s1, g1);
    assign pend3_d = pend_next(pend3_q, s3, g3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend1_q <= '0;
            pend3_q <= '0;
            pix1_q  <= '0;
            pix3_q  <= '0;
            wrap1_q <= 1'b0;
            wrap3_q <= 1'b0;
            f1_q    <= 1'b0;
            f3_q    <= 1'b0;
            last3_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            pend1_q <= '0;
            pend3_q <= '0;
            pix1_q  <= '0;
            pix3_q  <= '0;
            wrap1_q <= 1'b0;
            wrap3_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pend1_q <= pend1_d;
            pend3_q <= pend3_d;
            if (g1) begin
                if (pix1_q == PW'(NPIX-1)) begin
                    pix1_q  <= '0;
                    wrap1_q <= 1'b1;
                end else begin
                    pix1_q  <= pix1_q + 1'b1;
                end
            end
            if (g3) begin
                if (pix3_q == PW'(NPIX-1)) begin
                    pix3_q  <= '0;
                    wrap3_q <= 1'b1;
                end else begin
                    pix3_q  <= pix3_q + 1'b1;
                end
            end
            if (g1 || g3) last3_q <= g3;
            if (ovf1 || ovf3 || (enter_done && bad_count)) err_q <= 1'b1;
            if (enter_exp) begin
                f1_q <= 1'b0;
                f3_q <= 1'b0;
            end else if (state_q == EXPAND) begin
                f1_q <= f1_q | bus.e1_finish;
                f3_q <= f3_q | bus.e3_finish;
            end
        end
    end

    assign bus.wr_en        = g1 | g3;
    assign bus.wr_sel       = g3;
    assign bus.wr_addr      = {g3, (g3 ? pix3_q : pix1_q)};
    assign bus.ram_feedback = (pend1_q != 2'd0) || (pend3_q != 2'd0);
    assign bus.err          = err_q;
endmodule

// File: tb/tb_fire4_scheduler.sv
// Bench for fire4_scheduler (WOUT=4): scenario tasks compare the DUT every cycle against
// a cycle-level behavioural model built from the pass/arbitration rules.
module tb_fire4_scheduler;
    localparam int WOUT = 4;
    localparam int NPIX = WOUT * WOUT;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fire4_scheduler_if #(.AW(AW)) bus ();
    fire4_scheduler #(.WOUT(WOUT), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    // Model state: m_st 0=idle 1=squeeze 2=expand 3=done; m_n* are plain write totals.
    int m_st, m_p1, m_p3, m_n1, m_n3;
    bit m_last3, m_f1, m_f3, m_err;

    function automatic logic [13:0] obs();
        return {bus.busy, bus.sq_en, bus.e1_en, bus.e3_en, bus.wr_en, bus.wr_sel,
                bus.wr_addr, bus.ram_feedback, bus.done, bus.err};
    endfunction

    function automatic logic [13:0] expv();
        bit g1, g3;
        logic [AW-1:0] a;
        g1 = (m_p1 > 0) && (m_p3 == 0 || m_last3);
        g3 = (m_p3 > 0) && (m_p1 == 0 || !m_last3);
        a  = AW'(g3 ? NPIX + (m_n3 % NPIX) : (m_n1 % NPIX));
        return {m_st != 0, m_st == 1, m_st == 2, m_st == 2, g1 | g3, g3, a,
                (m_p1 > 0) || (m_p3 > 0), m_st == 3, m_err};
    endfunction

    task automatic model_reset();
        m_st = 0; m_p1 = 0; m_p3 = 0; m_n1 = 0; m_n3 = 0;
        m_last3 = 0; m_f1 = 0; m_f3 = 0; m_err = 0;
    endtask

    task automatic model_step(input bit st, sqf, s1, s3, f1, f3);
        bit g1, g3, c1, c3, bad;
        int nst;
        if (m_st == 0 && st) begin
            m_st = 1; m_p1 = 0; m_p3 = 0; m_n1 = 0; m_n3 = 0; m_err = 0;
            return;
        end
        g1  = (m_p1 > 0) && (m_p3 == 0 || m_last3);
        g3  = (m_p3 > 0) && (m_p1 == 0 || !m_last3);
        bad = (m_n1 != NPIX) || (m_n3 != NPIX);
        c1  = (m_st == 2) && s1;
        c3  = (m_st == 2) && s3;
        if (c1 && m_p1 == 2 && !g1) begin m_err = 1; c1 = 0; end
        if (c3 && m_p3 == 2 && !g3) begin m_err = 1; c3 = 0; end
        m_p1 = m_p1 + int'(c1) - int'(g1);
        m_p3 = m_p3 + int'(c3) - int'(g3);
        m_n1 = m_n1 + int'(g1);
        m_n3 = m_n3 + int'(g3);
        if (g1 || g3) m_last3 = g3;
        nst = m_st;
        case (m_st)
            1: if (sqf) begin nst = 2; m_f1 = 0; m_f3 = 0; end
            2: if (m_f1 && m_f3) begin
                   nst = 3;
                   if (bad) m_err = 1;
               end else begin
                   m_f1 = m_f1 | f1;
                   m_f3 = m_f3 | f3;
               end
            3: nst = 0;
            default: ;
        endcase
        m_st = nst;
    endtask

    // Drive one clock of inputs (starting at a negedge), advance model, return at next negedge.
    task automatic cyc(input bit st, sqf, s1, s3, f1, f3);
        bus.start = st; bus.sq_finish = sqf; bus.e1_sample = s1; bus.e3_sample = s3;
        bus.e1_finish = f1; bus.e3_finish = f3;
        model_step(st, sqf, s1, s3, f1, f3);
        @(negedge clk);
        bus.start = 0; bus.sq_finish = 0; bus.e1_sample = 0; bus.e3_sample = 0;
        bus.e1_finish = 0; bus.e3_finish = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic finish_pass();
        for (int k = 0; k < 8 && (m_p1 != 0 || m_p3 != 0); k++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        bus.start = 0; bus.sq_finish = 0; bus.e1_sample = 0; bus.e3_sample = 0;
        bus.e1_finish = 0; bus.e3_finish = 0;
        model_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (obs() !== 14'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want %b", obs(), 14'd0);
        end
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        n_chk++;
        if (obs() !== expv()) begin
            n_fail++; $display("FAIL reset_idle: got %b want %b", obs(), expv());
        end
    endtask

    task automatic test_nominal();
        int q1[$], q3[$], dones;
        cyc(1, 0, 0, 0, 0, 0);
        n_chk++;
        if (obs() !== expv()) begin n_fail++; $display("FAIL nom_start: got %b want %b", obs(), expv()); end
        repeat (9) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        n_chk++;
        if (obs() !== expv()) begin n_fail++; $display("FAIL nom_expand: got %b want %b", obs(), expv()); end
        dones = 0;
        for (int c = 0; c < 15*289 + 6; c++) begin
            cyc(0, 0, (c % 33 == 0) && (c / 33 < 16), (c % 289 == 0) && (c / 289 < 16), 0, 0);
            n_chk++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL nom_cycle %0d: got %b want %b", c, obs(), expv());
            end
            if (bus.wr_en) begin
                if (bus.wr_sel) q3.push_back(int'(bus.wr_addr));
                else            q1.push_back(int'(bus.wr_addr));
            end
        end
        cyc(0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            n_chk++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL nom_end %0d: got %b want %b", k, obs(), expv()); end
            if (bus.done) begin
                dones++;
                n_chk++;
                if (bus.err !== 1'b0) begin n_fail++; $display("FAIL nom_err: got %b want 0", bus.err); end
            end
        end
        n_chk++;
        if (dones != 1) begin n_fail++; $display("FAIL nom_done_count: got %0d want 1", dones); end
        n_chk++;
        if (q1.size() != NPIX || q3.size() != NPIX) begin
            n_fail++; $display("FAIL nom_write_count: got %0d/%0d want %0d/%0d", q1.size(), q3.size(), NPIX, NPIX);
        end else begin
            for (int i = 0; i < NPIX; i++) begin
                n_chk++;
                if (q1[i] != i || q3[i] != NPIX + i) begin
                    n_fail++; $display("FAIL nom_addr %0d: got %0d/%0d want %0d/%0d", i, q1[i], q3[i], i, NPIX + i);
                end
            end
        end
    endtask

    task automatic test_collision();
        bit  es[4];
        int  ea[4];
        es = '{1, 0, 1, 0};
        ea = '{NPIX, 0, NPIX + 1, 1};
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, i < 2, i < 2, 0, 0);
            n_chk++;
            if ({bus.wr_en, bus.wr_sel, bus.wr_addr} !== {1'b1, es[i], AW'(ea[i])}) begin
                n_fail++; $display("FAIL collision %0d: got en=%b sel=%b addr=%0d want en=1 sel=%b addr=%0d",
                                   i, bus.wr_en, bus.wr_sel, bus.wr_addr, es[i], ea[i]);
            end
            n_chk++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL collision_model %0d: got %b want %b", i, obs(), expv()); end
        end
        finish_pass();
    endtask

    task automatic test_overflow();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 1, 0, 0);
            n_chk++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL overflow_model %0d: got %b want %b", i, obs(), expv()); end
        end
        n_chk++;
        if (bus.err !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %b want 1", bus.err); end
        finish_pass();
        cyc(1, 0, 0, 0, 0, 0);
        n_chk++;
        if (bus.err !== 1'b0) begin n_fail++; $display("FAIL overflow_err_clear: got %b want 0", bus.err); end
        cyc(0, 1, 0, 0, 0, 0);
        finish_pass();
    endtask

    task automatic test_stray();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 0, 0);
            n_chk++;
            if (bus.wr_en !== 1'b0 || bus.ram_feedback !== 1'b0) begin
                n_fail++; $display("FAIL stray_idle %0d: got wr_en=%b rf=%b want 0/0", i, bus.wr_en, bus.ram_feedback);
            end
        end
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 1, 0, 0);
            n_chk++;
            if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL stray_squeeze %0d: got wr_en=%b want 0", i, bus.wr_en); end
        end
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        n_chk++;
        if ({bus.wr_en, bus.wr_sel, bus.wr_addr} !== {1'b1, 1'b0, AW'(0)}) begin
            n_fail++; $display("FAIL stray_pix: got en=%b sel=%b addr=%0d want en=1 sel=0 addr=0",
                               bus.wr_en, bus.wr_sel, bus.wr_addr);
        end
        finish_pass();
    endtask

    task automatic test_mismatch();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < NPIX; i++) begin
            cyc(0, 0, i < NPIX - 1, 1, 0, 0);
            cyc(0, 0, 0, 0, 0, 0);
            n_chk++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL mismatch_model %0d: got %b want %b", i, obs(), expv()); end
        end
        for (int k = 0; k < 8 && (m_p1 != 0 || m_p3 != 0); k++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        n_chk++;
        if ({bus.done, bus.err} !== 2'b11) begin
            n_fail++; $display("FAIL mismatch_err: got done=%b err=%b want 1/1", bus.done, bus.err);
        end
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_async_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 0);
        n_chk++;
        if (!(m_p1 == 2 || m_p3 == 2) || obs() !== expv()) begin
            n_fail++; $display("FAIL areset_setup: got %b want %b", obs(), expv());
        end
        #2 rst = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (obs() !== 14'd0) begin n_fail++; $display("FAIL areset_immediate: got %b want 0", obs()); end
        @(negedge clk);
        n_chk++;
        if (obs() !== expv()) begin n_fail++; $display("FAIL areset_hold: got %b want %b", obs(), expv()); end
        rst = 1'b1;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        n_chk++;
        if ({bus.wr_en, bus.wr_sel, bus.wr_addr, bus.err} !== {1'b1, 1'b0, AW'(0), 1'b0}) begin
            n_fail++; $display("FAIL areset_clean_pass: got en=%b sel=%b addr=%0d err=%b want 1/0/0/0",
                               bus.wr_en, bus.wr_sel, bus.wr_addr, bus.err);
        end
        finish_pass();
    endtask

    task automatic test_random();
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int c = 0; c < 400; c++) begin
            cyc(0, 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 0, 0);
            n_chk++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL random_cycle %0d: got %b want %b", c, obs(), expv()); end
        end
        for (int k = 0; k < 8 && (m_p1 != 0 || m_p3 != 0); k++) cyc(0, 0, 0, 0, 0, 0);
        n_chk++;
        if (bus.ram_feedback !== 1'b0) begin n_fail++; $display("FAIL random_drain: got rf=%b want 0", bus.ram_feedback); end
        cyc(0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 0);
            n_chk++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL random_end %0d: got %b want %b", k, obs(), expv()); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_collision();
        test_overflow();
        test_stray();
        test_mismatch();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
